// File: rtl/inst_rom_loader.sv
// Instruction ROM for the core's fetch port. A host can load it with a big-endian
// byte stream, which is packed into words and written sequentially from word 0.
//
// state | meaning
// IDLE  | fetches are served from memory; the loader ignores bytes and load_end
// LOAD  | bytes are accepted and packed into words; fetches return NOP (0)
module inst_rom_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic [31:0]       addr,
   output logic [31:0]       inst,
   input  logic              load_start,
   input  logic              load_end,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              busy,
   output logic [ADDR_W:0]   words_loaded,
   output logic              partial_err,
   output logic              full
);

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] wptr;
   logic [1:0]        byte_cnt, cnt_nxt;
   logic [23:0]       shreg;
   logic [31:0]       mem [2**ADDR_W];

   logic restart, accept, word_done, last_word, end_load;
   logic [31:0] word_addr;
   logic        in_range;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      byte_ready = 1'b0;
      busy       = 1'b0;
      restart    = 1'b0;
      accept     = 1'b0;
      word_done  = 1'b0;
      last_word  = 1'b0;
      end_load   = 1'b0;
      case (state)
         IDLE: begin
            if (load_start) begin
               restart   = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (load_start) begin
               restart = 1'b1;
            end else begin
               accept    = byte_valid;
               word_done = accept && (byte_cnt == 2'd3);
               last_word = word_done && (wptr == {ADDR_W{1'b1}});
               if (last_word) begin
                  state_nxt = IDLE;
               end else if (load_end) begin
                  end_load  = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Wraps 3 -> 0 on the fourth byte, which doubles as the "no bytes pending" test.
   assign cnt_nxt = byte_cnt + {1'b0, accept};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr         <= '0;
         byte_cnt     <= '0;
         shreg        <= '0;
         words_loaded <= '0;
         partial_err  <= 1'b0;
         full         <= 1'b0;
      end else if (restart) begin
         wptr         <= '0;
         byte_cnt     <= '0;
         words_loaded <= '0;
         partial_err  <= 1'b0;
         full         <= 1'b0;
      end else begin
         if (accept)    shreg <= {shreg[15:0], byte_data};
         if (word_done) begin
            wptr         <= wptr + 1'b1;
            words_loaded <= words_loaded + 1'b1;
         end
         if (last_word) full <= 1'b1;
         if (end_load) begin
            partial_err <= (cnt_nxt != 2'd0);
            byte_cnt    <= '0;
         end else begin
            byte_cnt <= cnt_nxt;
         end
      end
   end

   // Memory is deliberately not reset so a loaded program survives a core reset.
   always_ff @(posedge clk) begin
      if (word_done) mem[wptr] <= {shreg, byte_data};
   end

   assign word_addr = addr >> 2;
   assign in_range  = (word_addr[31:ADDR_W] == '0);
   assign inst      = (rst && ce && !busy && in_range) ? mem[word_addr[ADDR_W-1:0]] : 32'h0;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: a default-size instance plus a 4-word instance
// for the memory-full case, both driven from the same stimulus.
module tb_inst_rom_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic [31:0] addr;
   logic        load_start, load_end, byte_valid;
   logic [7:0]  byte_data;

   logic [31:0] inst, inst_s;
   logic        byte_ready, busy, partial_err, full;
   logic        byte_ready_s, busy_s, partial_err_s, full_s;
   logic [10:0] words_loaded;
   logic [2:0]  words_loaded_s;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   inst_rom_loader #(.ADDR_W(10)) dut (
      .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
      .load_start(load_start), .load_end(load_end),
      .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(byte_ready), .busy(busy), .words_loaded(words_loaded),
      .partial_err(partial_err), .full(full)
   );

   inst_rom_loader #(.ADDR_W(2)) dut_s (
      .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_s),
      .load_start(load_start), .load_end(load_end),
      .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(byte_ready_s), .busy(busy_s), .words_loaded(words_loaded_s),
      .partial_err(partial_err_s), .full(full_s)
   );

   // Stimulus helpers: all drive changes happen at the falling edge.
   task automatic send_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'hFF;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic pulse_end();
      load_end = 1'b1;
      @(negedge clk);
      load_end = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; ce = 1'b1; addr = 32'h0;
      load_start = 1'b0; load_end = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      repeat (3) @(negedge clk);
      tests_run++;
      if (inst !== 32'h0 || inst_s !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_inst: got %h/%h expected 00000000", inst, inst_s);
      end
      tests_run++;
      if ({byte_ready, busy, partial_err, full} !== 4'b0 || words_loaded !== 11'd0) begin
         tests_failed++;
         $display("FAIL reset_status: got rdy=%b busy=%b perr=%b full=%b wl=%0d expected all 0",
                  byte_ready, busy, partial_err, full, words_loaded);
      end
      tests_run++;
      if ({byte_ready_s, busy_s, partial_err_s, full_s} !== 4'b0 || words_loaded_s !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset_status_small: got rdy=%b busy=%b perr=%b full=%b wl=%0d expected all 0",
                  byte_ready_s, busy_s, partial_err_s, full_s, words_loaded_s);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic_load();
      logic [7:0] img [8] = '{8'h34, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
      pulse_start();
      send_byte(img[0]);
      tests_run++;
      if (busy !== 1'b1 || byte_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_busy: got busy=%b rdy=%b expected 1/1", busy, byte_ready);
      end
      tests_run++;
      if (inst !== 32'h0) begin
         tests_failed++;
         $display("FAIL basic_fetch_during_load: got %h expected 00000000", inst);
      end
      for (int i = 1; i < 8; i++) send_byte(img[i]);
      tests_run++;
      if (words_loaded !== 11'd2) begin
         tests_failed++;
         $display("FAIL basic_words: got %0d expected 2", words_loaded);
      end
      pulse_end();
      tests_run++;
      if (busy !== 1'b0 || partial_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_end: got busy=%b perr=%b expected 0/0", busy, partial_err);
      end
      addr = 32'h0; #1;
      tests_run++;
      if (inst !== 32'h34010005) begin
         tests_failed++;
         $display("FAIL basic_word0: got %h expected 34010005", inst);
      end
      addr = 32'h4; #1;
      tests_run++;
      if (inst !== 32'h00000000) begin
         tests_failed++;
         $display("FAIL basic_word1: got %h expected 00000000", inst);
      end
      addr = 32'h5; #1;
      tests_run++;
      if (inst !== 32'h00000000) begin
         tests_failed++;
         $display("FAIL basic_unaligned: got %h expected 00000000", inst);
      end
      addr = 32'h0; ce = 1'b0; #1;
      tests_run++;
      if (inst !== 32'h0) begin
         tests_failed++;
         $display("FAIL basic_ce_low: got %h expected 00000000", inst);
      end
      ce = 1'b1;
   endtask

   task automatic test_gapped();
      logic [7:0] img [4] = '{8'h34, 8'h02, 8'h00, 8'h0A};
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         send_byte(img[i]);
         if (i == 2) begin
            tests_run++;
            if (words_loaded !== 11'd0) begin
               tests_failed++;
               $display("FAIL gapped_three_bytes: got %0d words expected 0", words_loaded);
            end
         end
         @(negedge clk);
      end
      tests_run++;
      if (words_loaded !== 11'd1) begin
         tests_failed++;
         $display("FAIL gapped_words: got %0d expected 1", words_loaded);
      end
      pulse_end();
      addr = 32'h0; #1;
      tests_run++;
      if (inst !== 32'h3402000A) begin
         tests_failed++;
         $display("FAIL gapped_word0: got %h expected 3402000a", inst);
      end
   endtask

   task automatic test_partial();
      logic [7:0] img [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      pulse_start();
      for (int i = 0; i < 6; i++) send_byte(img[i]);
      pulse_end();
      tests_run++;
      if (words_loaded !== 11'd1 || partial_err !== 1'b1 || byte_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL partial_status: got wl=%0d perr=%b rdy=%b expected 1/1/0",
                  words_loaded, partial_err, byte_ready);
      end
      addr = 32'h0; #1;
      tests_run++;
      if (inst !== 32'h11223344) begin
         tests_failed++;
         $display("FAIL partial_word0: got %h expected 11223344", inst);
      end
      addr = 32'h4; #1;
      tests_run++;
      if (inst !== 32'h00000000) begin
         tests_failed++;
         $display("FAIL partial_word1_kept: got %h expected 00000000", inst);
      end
   endtask

   // Fourth byte arrives on the same edge as load_end.
   task automatic test_back_to_back();
      pulse_start();
      send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
      load_end = 1'b1;
      send_byte(8'hA4);
      load_end = 1'b0;
      tests_run++;
      if (words_loaded !== 11'd1 || partial_err !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_end_with_byte: got wl=%0d perr=%b busy=%b expected 1/0/0",
                  words_loaded, partial_err, busy);
      end
      addr = 32'h0; #1;
      tests_run++;
      if (inst !== 32'hA1A2A3A4) begin
         tests_failed++;
         $display("FAIL b2b_word0: got %h expected a1a2a3a4", inst);
      end
   endtask

   task automatic test_full();
      pulse_start();
      for (int i = 1; i <= 16; i++) send_byte(8'(i));
      tests_run++;
      if (full_s !== 1'b1 || busy_s !== 1'b0 || byte_ready_s !== 1'b0 || words_loaded_s !== 3'd4) begin
         tests_failed++;
         $display("FAIL full_status: got full=%b busy=%b rdy=%b wl=%0d expected 1/0/0/4",
                  full_s, busy_s, byte_ready_s, words_loaded_s);
      end
      tests_run++;
      if (full !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL full_large_unaffected: got full=%b busy=%b expected 0/1", full, busy);
      end
      for (int i = 17; i <= 20; i++) send_byte(8'(i));
      tests_run++;
      if (words_loaded_s !== 3'd4 || full_s !== 1'b1) begin
         tests_failed++;
         $display("FAIL full_extra_bytes: got wl=%0d full=%b expected 4/1", words_loaded_s, full_s);
      end
      pulse_end();
      tests_run++;
      if (words_loaded !== 11'd5 || partial_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_large_words: got wl=%0d perr=%b expected 5/0", words_loaded, partial_err);
      end
      addr = 32'hC; #1;
      tests_run++;
      if (inst_s !== 32'h0D0E0F10) begin
         tests_failed++;
         $display("FAIL full_last_word: got %h expected 0d0e0f10", inst_s);
      end
      addr = 32'h10; #1;
      tests_run++;
      if (inst_s !== 32'h0 || inst !== 32'h11121314) begin
         tests_failed++;
         $display("FAIL full_out_of_range: got small=%h large=%h expected 00000000/11121314",
                  inst_s, inst);
      end
   endtask

   task automatic test_restart();
      pulse_start();
      send_byte(8'h11); send_byte(8'h22);
      load_start = 1'b1; load_end = 1'b1;
      send_byte(8'h99);
      load_start = 1'b0; load_end = 1'b0;
      tests_run++;
      if (words_loaded !== 11'd0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL restart_status: got wl=%0d busy=%b expected 0/1", words_loaded, busy);
      end
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      pulse_end();
      tests_run++;
      if (words_loaded !== 11'd1 || partial_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL restart_words: got wl=%0d perr=%b expected 1/0", words_loaded, partial_err);
      end
      addr = 32'h0; #1;
      tests_run++;
      if (inst !== 32'hAABBCCDD) begin
         tests_failed++;
         $display("FAIL restart_word0: got %h expected aabbccdd", inst);
      end
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] img [10] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h01, 8'h02};
      pulse_start();
      for (int i = 0; i < 10; i++) send_byte(img[i]);
      #2 rst = 1'b0;
      #1;
      tests_run++;
      if (busy !== 1'b0 || byte_ready !== 1'b0 || words_loaded !== 11'd0 || inst !== 32'h0) begin
         tests_failed++;
         $display("FAIL rst_mid_load: got busy=%b rdy=%b wl=%0d inst=%h expected 0/0/0/00000000",
                  busy, byte_ready, words_loaded, inst);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      addr = 32'h0; #1;
      tests_run++;
      if (inst !== 32'h12345678) begin
         tests_failed++;
         $display("FAIL rst_word0_kept: got %h expected 12345678", inst);
      end
      addr = 32'h4; #1;
      tests_run++;
      if (inst !== 32'h9ABCDEF0) begin
         tests_failed++;
         $display("FAIL rst_word1_kept: got %h expected 9abcdef0", inst);
      end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_gapped();
      test_partial();
      test_back_to_back();
      test_full();
      test_restart();
      test_reset_mid_load();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
